// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE picks the next owner, GRANT streams its words.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Reset values of the registered outputs and the FSM.
    localparam arb_state_e RST_STATE = IDLE;
    localparam logic       RST_WINC  = 1'b0;
    localparam logic       RST_OVF   = 1'b0;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first active request after rr_last, wrapping around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_last,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0] NREQ_W = (IW + 1)'(NREQ);

    // Duplicating the vector lets a single part-select perform the rotation.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IW:0]       base;
    logic [IW:0]       off;
    logic [IW:0]       sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dbl
            assign req_dbl[gi]        = req[gi];
            assign req_dbl[gi + NREQ] = req[gi];
        end
    endgenerate

    assign base    = {1'b0, rr_last} + (IW + 1)'(1);
    assign req_rot = req_dbl[base +: NREQ];

    // Lowest set bit of the rotated vector is the winner; map back to an index.
    always_comb begin
        any = 1'b0;
        off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req_rot[k]) begin
                any = 1'b1;
                off = (IW + 1)'(k);
            end
        end
        sum = base + off;
        idx = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin sharing of the async FIFO write port between NREQ requesters,
// with burst limiting, full/almost-full throttling and registered winc/wdata.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DSIZE = 16,
    parameter  int BURST = 4,
    localparam int OW    = clog2(NREQ),
    localparam int BW    = clog2(BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    input  logic                  wfull_almost,
    input  logic                  err_clr,
    output logic                  ovf_err
);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

    arb_state_e       state_q,   state_d;
    logic [OW-1:0]    owner_q,   owner_d;
    logic [OW-1:0]    rr_last_q, rr_last_d;
    logic [BW-1:0]    beat_q,    beat_d;
    logic             winc_q,    winc_d;
    logic [DSIZE-1:0] wdata_q,   wdata_d;
    logic             ovf_q,     ovf_d;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic [OW-1:0]    pick_idx;
    logic             pick_any;
    logic             room;
    logic             own_req;
    logic             own_last;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
        end
    endgenerate

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req    (req),
        .rr_last(rr_last_q),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // A write already in flight consumes the last free slot when almost full.
    assign room     = ~wfull & ~(wfull_almost & winc_q);
    assign own_req  = req[owner_q];
    assign own_last = req_last[owner_q];

    // Next-state, burst counting, ack generation and write staging.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        beat_d    = beat_q;
        winc_d    = 1'b0;
        wdata_d   = wdata_q;
        ack       = '0;
        case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (own_req && room) begin
                    ack[owner_q] = 1'b1;
                    winc_d       = 1'b1;
                    wdata_d      = data_arr[owner_q];
                    beat_d       = beat_q + BW'(1);
                end
                // Withdrawal, end of packet or full burst each end the grant once.
                if (!own_req || (room && (own_last || beat_q == BEAT_LAST))) begin
                    state_d   = IDLE;
                    rr_last_d = owner_q;
                end
            end
        endcase
        // Overflow set has priority over a same-cycle clear.
        ovf_d = (winc_q & wfull) | (ovf_q & ~err_clr);
    end

    // State and output registers; reset drops any staged write.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q   <= RST_STATE;
            owner_q   <= '0;
            rr_last_q <= OW'(NREQ - 1);
            beat_q    <= '0;
            winc_q    <= RST_WINC;
            wdata_q   <= '0;
            ovf_q     <= RST_OVF;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            beat_q    <= beat_d;
            winc_q    <= winc_d;
            wdata_q   <= wdata_d;
            ovf_q     <= ovf_d;
        end
    end

    assign owner   = owner_q;
    assign busy    = (state_q == GRANT);
    assign winc    = winc_q;
    assign wdata   = wdata_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (NREQ=4, DSIZE=16, BURST=4).
module tb_fifo_wr_arb;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        en;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic        winc;
    logic [15:0] wdata;
    logic        wfull;
    logic        wfull_almost;
    logic        err_clr;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    // Requester model: word k of requester i is 0xA000 + i*256 + k.
    logic [7:0]  cnt     [4];
    logic [7:0]  last_at [4];
    logic [15:0] wq [$];
    int          wq_base;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(
        .NREQ (4),
        .DSIZE(16),
        .BURST(4)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .owner       (owner),
        .busy        (busy),
        .winc        (winc),
        .wdata       (wdata),
        .wfull       (wfull),
        .wfull_almost(wfull_almost),
        .err_clr     (err_clr),
        .ovf_err     (ovf_err)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign req_data[gi*16 +: 16] = 16'hA000 + 16'(gi * 256) + 16'(cnt[gi]);
            assign req_last[gi]          = (cnt[gi] == last_at[gi]);
        end
    endgenerate

    // Requesters advance to their next word on every ack; reset flushes them.
    always @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i] <= cnt[i] + 8'd1;
        end
    end

    // FIFO write log.
    always @(negedge wclk) begin
        if (winc) wq.push_back(wdata);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Ends at posedge+1 with reset released and all inputs quiet.
    task automatic do_reset();
        wrst = 1'b1;
        req = 4'b0; en = 1'b0; wfull = 1'b0; wfull_almost = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 4; i++) last_at[i] = 8'hFF;
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
        wq_base = wq.size();
    endtask

    // One clock cycle: apply inputs, check ack/busy mid-cycle, advance to posedge+1.
    task automatic drive_cyc(input string tag, input int n, input logic [3:0] r, input logic e,
                             input logic f, input logic fa, input logic [3:0] ea, input logic eb);
        req = r; en = e; wfull = f; wfull_almost = fa;
        @(negedge wclk);
        chk($sformatf("%s%0d.ack", tag, n), 32'(ack), 32'(ea));
        chk($sformatf("%s%0d.busy", tag, n), 32'(busy), 32'(eb));
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        wrst = 1'b0;
        #2;
        // 1: reset state, then async reset mid-burst.
        do_reset();
        chk("rst.winc", 32'(winc), 32'd0);
        chk("rst.wdata", 32'(wdata), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.ovf", 32'(ovf_err), 32'd0);
        chk("rst.ack", 32'(ack), 32'd0);
        drive_cyc("t1c", 0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t1c", 1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        chk("t1.winc", 32'(winc), 32'd1);
        chk("t1.wdata", 32'(wdata), 32'hA000);
        #2;
        wrst = 1'b1;
        #1;
        chk("t1.async_winc", 32'(winc), 32'd0);
        chk("t1.async_wdata", 32'(wdata), 32'd0);
        chk("t1.async_busy", 32'(busy), 32'd0);

        // 2: all requesting, bursts of 4, order 0,1,2,3,0 with one bubble each.
        do_reset();
        for (int t = 0; t < 22; t++) begin
            drive_cyc("rr", t, 4'b1111, 1'b1, 1'b0, 1'b0,
                      (t % 5 == 0) ? 4'b0000 : 4'(1 << ((t / 5) % 4)), (t % 5 != 0));
        end
        chk("rr.winc", 32'(winc), 32'd1);
        chk("rr.wdata", 32'(wdata), 32'hA004);
        chk("rr.nwords", 32'(wq.size() - wq_base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rr.word%0d", k), 32'(wq[wq_base + k]),
                32'h0000A000 + 32'((k / 4) * 256 + (k % 4)));
        end

        // 3: single requester, packet of 2 words, re-grant after bubble.
        do_reset();
        last_at[2] = 8'd1;
        drive_cyc("t3c", 0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t3c", 1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
        drive_cyc("t3c", 2, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
        drive_cyc("t3c", 3, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t3c", 4, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
        chk("t3.owner", 32'(owner), 32'd2);

        // 4: almost-full with pending write, then full stall, then resume.
        do_reset();
        drive_cyc("t4c", 0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t4c", 1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        drive_cyc("t4c", 2, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1);
        drive_cyc("t4c", 3, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_cyc("t4c", 4, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_cyc("t4c", 5, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        drive_cyc("t4c", 6, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        drive_cyc("t4c", 7, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        drive_cyc("t4c", 8, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t4.nwords", 32'(wq.size() - wq_base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4.word%0d", k), 32'(wq[wq_base + k]), 32'h0000A000 + 32'(k));
        end
        chk("t4.ovf", 32'(ovf_err), 32'd0);

        // 5: en dropped during burst of requester 1.
        do_reset();
        drive_cyc("t5c", 0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        for (int t = 1; t < 5; t++) drive_cyc("t5c", t, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1);
        for (int t = 5; t < 9; t++) drive_cyc("t5c", t, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t5c", 9, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t5c", 10, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
        chk("t5.owner", 32'(owner), 32'd2);

        // 6: write lands on a FIFO claiming full -> sticky ovf_err, clear, set-over-clear.
        do_reset();
        drive_cyc("t6c", 0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t6c", 1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        drive_cyc("t6c", 2, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        chk("t6.ovf_set", 32'(ovf_err), 32'd1);
        drive_cyc("t6c", 3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
        chk("t6.ovf_sticky", 32'(ovf_err), 32'd1);
        err_clr = 1'b1;
        drive_cyc("t6c", 4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        err_clr = 1'b0;
        chk("t6.ovf_clr", 32'(ovf_err), 32'd0);
        drive_cyc("t6c", 5, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cyc("t6c", 6, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        err_clr = 1'b1;
        drive_cyc("t6c", 7, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        err_clr = 1'b0;
        chk("t6.set_wins", 32'(ovf_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
